// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the CPU MEM stage and a
// DMA/debug loader. CPU has priority; DMA gets bounded bursts plus a starvation guard.
module dmem_arbiter #(
   parameter int MAX_BURST    = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [31:0] dma_addr,
   input  logic [31:0] dma_wdata,
   output logic        dma_gnt,
   output logic        dma_rvalid,
   output logic [31:0] dma_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);
   localparam int BW = $clog2(MAX_BURST + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic {CPU, DMA} state_t;

   state_t        state;
   logic [BW-1:0] burst_cnt;
   logic [SW-1:0] starve_cnt;
   logic          starved;
   logic          cpu_srv;

   // Every grant is qualified by reset so nothing reaches memory while reset is low.
   always_comb begin
      starved   = starve_cnt == SW'(STARVE_LIMIT);
      dma_gnt   = reset && dma_req && (state == CPU ? (starved || !cpu_req) : burst_cnt < BW'(MAX_BURST));
      cpu_srv   = reset && cpu_req && !dma_gnt;
      cpu_stall = reset && cpu_req && !cpu_srv;
      mem_en    = cpu_srv || dma_gnt;
      mem_we    = dma_gnt ? dma_we : cpu_srv && cpu_we;
      mem_addr  = dma_gnt ? dma_addr : cpu_srv ? cpu_addr : '0;
      mem_wdata = dma_gnt ? dma_wdata : cpu_srv ? cpu_wdata : '0;
      cpu_rdata = cpu_srv ? mem_rdata : '0;
   end

   // A non-granted cycle always hands the port back to the CPU, so the burst ends there.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= CPU;
         burst_cnt  <= '0;
         starve_cnt <= '0;
         dma_rvalid <= 1'b0;
         dma_rdata  <= '0;
      end else begin
         state      <= dma_gnt ? DMA : CPU;
         burst_cnt  <= !dma_gnt ? '0 : state == CPU ? BW'(1) : burst_cnt + 1'b1;
         starve_cnt <= (!dma_req || dma_gnt) ? '0 : starved ? starve_cnt : starve_cnt + 1'b1;
         dma_rvalid <= dma_gnt && !dma_we;
         if (dma_gnt && !dma_we)
            dma_rdata <= mem_rdata;
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a read-data scoreboard for dmem_arbiter.
module tb_dmem_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we, dma_req, dma_we;
   logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
   logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        cpu_stall, dma_gnt, dma_rvalid, mem_en, mem_we;
   logic [31:0] mem [0:255];
   logic [31:0] q[$];
   logic        pend;
   int          checks = 0;
   int          failures = 0;
   int          n;

   dmem_arbiter #(.MAX_BURST(4), .STARVE_LIMIT(8)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory is preloaded with a recognisable pattern while reset is held.
   assign mem_rdata = mem[mem_addr[9:2]];
   always @(posedge clk) begin
      if (!reset)
         for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + i;
      else if (mem_en && mem_we)
         mem[mem_addr[9:2]] <= mem_wdata;
   end

   function automatic logic [31:0] pattern(input logic [31:0] a);
      return 32'hA000_0000 + {24'b0, a[9:2]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: each granted DMA read pushes its expected data, popped when rvalid appears.
   always @(negedge clk) begin
      if (!reset) begin
         pend = 1'b0;
         q.delete();
      end else begin
         chk("dma_rvalid", {31'b0, dma_rvalid}, {31'b0, pend});
         if (pend && dma_rvalid && q.size() > 0)
            chk("dma_rdata", dma_rdata, q.pop_front());
         pend = dma_gnt && !dma_we;
         if (pend)
            q.push_back(pattern(dma_addr));
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; cpu_wdata = '0;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h100; dma_wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_en", {31'b0, mem_en}, 0);
      chk("rst_mem_we", {31'b0, mem_we}, 0);
      chk("rst_dma_gnt", {31'b0, dma_gnt}, 0);
      chk("rst_stall", {31'b0, cpu_stall}, 0);
      chk("rst_rvalid", {31'b0, dma_rvalid}, 0);
      step();
      reset = 1'b1;
      @(negedge clk);
      chk("first_cpu_en", {31'b0, mem_en}, 1);
      chk("first_dma_gnt", {31'b0, dma_gnt}, 0);
      chk("first_stall", {31'b0, cpu_stall}, 0);
      chk("first_addr", mem_addr, 32'h40);
      chk("first_rdata", cpu_rdata, 32'hA000_0010);
      step();
      dma_req = 1'b0; cpu_req = 1'b0;
      step();

      // Idle CPU, six back-to-back DMA reads
      n = 0; dma_req = 1'b1; dma_addr = 32'h100;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk("burst_gnt", {31'b0, dma_gnt}, {31'b0, n < 6 && c != 4});
         chk("burst_stall", {31'b0, cpu_stall}, 0);
         if (dma_gnt) n++;
         step();
         dma_addr = 32'h100 + 4 * n;
         dma_req = n < 6;
      end
      chk("burst_count", n, 6);

      // Starvation guard with the CPU requesting continuously
      n = 0; cpu_req = 1'b1; dma_req = 1'b1; dma_addr = 32'h180;
      for (int c = 0; c < 13; c++) begin
         @(negedge clk);
         chk("starve_gnt", {31'b0, dma_gnt}, {31'b0, c >= 8 && c < 12});
         chk("starve_stall", {31'b0, cpu_stall}, {31'b0, c >= 8 && c < 12});
         if (c == 12) chk("starve_cpu_rdata", cpu_rdata, 32'hA000_0010);
         if (dma_gnt) n++;
         step();
         dma_addr = 32'h180 + 4 * n;
      end
      dma_req = 1'b0;
      step();

      // Mid-burst release with the CPU waiting
      cpu_req = 1'b0; dma_req = 1'b1; dma_addr = 32'h1C0;
      @(negedge clk);
      chk("mid_gnt0", {31'b0, dma_gnt}, 1);
      step();
      cpu_req = 1'b1; dma_addr = 32'h1C4;
      @(negedge clk);
      chk("mid_gnt1", {31'b0, dma_gnt}, 1);
      chk("mid_stall1", {31'b0, cpu_stall}, 1);
      step();
      dma_req = 1'b0;
      @(negedge clk);
      chk("mid_rel_stall", {31'b0, cpu_stall}, 0);
      chk("mid_rel_en", {31'b0, mem_en}, 1);
      chk("mid_rel_addr", mem_addr, 32'h40);
      step();
      dma_req = 1'b1; dma_addr = 32'h1C8;
      @(negedge clk);
      chk("mid_state_cpu", {31'b0, dma_gnt}, 0);
      chk("mid_state_stall", {31'b0, cpu_stall}, 0);
      step();
      dma_req = 1'b0; cpu_req = 1'b0;
      step();

      // Write routing and idle port
      @(negedge clk);
      chk("idle_en", {31'b0, mem_en}, 0);
      chk("idle_we", {31'b0, mem_we}, 0);
      chk("idle_wdata", mem_wdata, 0);
      step();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("cpu_wr_we", {31'b0, mem_we}, 1);
      chk("cpu_wr_addr", mem_addr, 32'h20);
      chk("cpu_wr_data", mem_wdata, 32'hDEAD_BEEF);
      chk("cpu_wr_stall", {31'b0, cpu_stall}, 0);
      step();
      cpu_req = 1'b0; cpu_we = 1'b0;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h24; dma_wdata = 32'h1234_5678;
      @(negedge clk);
      chk("dma_wr_gnt", {31'b0, dma_gnt}, 1);
      chk("dma_wr_we", {31'b0, mem_we}, 1);
      chk("dma_wr_addr", mem_addr, 32'h24);
      chk("dma_wr_data", mem_wdata, 32'h1234_5678);
      step();
      dma_req = 1'b0; dma_we = 1'b0;
      cpu_req = 1'b1; cpu_addr = 32'h24;
      @(negedge clk);
      chk("cpu_ld_data", cpu_rdata, 32'h1234_5678);
      chk("cpu_ld_stall", {31'b0, cpu_stall}, 0);
      chk("cpu_ld_we", {31'b0, mem_we}, 0);
      step();
      chk("cpu_wr_mem", mem[8], 32'hDEAD_BEEF);
      cpu_req = 1'b0;
      step();

      // Reset asserted in the cycle after a DMA read grant
      dma_req = 1'b1; dma_addr = 32'h200;
      @(negedge clk);
      chk("rr_gnt", {31'b0, dma_gnt}, 1);
      step();
      reset = 1'b0; dma_req = 1'b0;
      #1;
      chk("rr_rvalid_async", {31'b0, dma_rvalid}, 0);
      chk("rr_mem_en", {31'b0, mem_en}, 0);
      step();
      step();
      reset = 1'b1;
      @(negedge clk);
      chk("rr_rvalid_after", {31'b0, dma_rvalid}, 0);
      step();
      @(negedge clk);
      chk("rr_rvalid_after2", {31'b0, dma_rvalid}, 0);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
